// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and counter widths
// for the CoreUART TX-side arbiter and its picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  localparam int TO_W  = 16;
  localparam int SET_W = 4;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin one-hot picker.
// Searches upward from last+1, wrapping at N-1.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  pick
);

  localparam int LW1 = LW + 1;

  logic [LW:0] pos;
  logic        found;

  // First valid requester after last, in wrapped order.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = {1'b0, last} + LW1'(k);
      if (pos >= LW1'(N)) begin
        pos = pos - LW1'(N);
      end
      if (!found && req[pos[LW-1:0]]) begin
        pick[pos[LW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one CoreUART write port between
// NUM_REQ byte sources with packet lock and TXRDY pacing.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int LOCK_TIMEOUT  = 1024
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [NUM_REQ*8-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_READY,
  input  logic                 UART_TXRDY,
  output logic                 UART_CSN,
  output logic                 UART_WEN,
  output logic [7:0]           UART_DATA,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 LOCK_ABORT
);

  localparam int LW = $clog2(NUM_REQ);
  localparam logic [LW-1:0] LAST_RST =
    LW'(NUM_REQ - 1);
  localparam logic [SET_W-1:0] SET_END =
    SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_END =
    TO_W'(LOCK_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LW-1:0]      last_q, last_d;
  logic [7:0]         data_q, data_d;
  logic [SET_W-1:0]   scnt_q, scnt_d;
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
  logic               abort_q, abort_d;
  logic               csn_q, wen_q, busy_q;

  logic [NUM_REQ-1:0] pick, sel, ready;
  logic [LW-1:0]      sel_idx;
  logic [7:0]         sel_data;
  logic               sel_last;

  uart_rr_pick #(
    .N  (NUM_REQ),
    .LW (LW)
  ) u_pick (
    .req  (REQ_VALID),
    .last (last_q),
    .pick (pick)
  );

  // Byte, LAST flag and index of the requester under consideration.
  always_comb begin
    sel      = (state_q == ST_IDLE) ? pick : grant_q;
    sel_data = '0;
    sel_last = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) begin
        sel_data = sel_data | REQ_DATA[8*i +: 8];
        sel_last = sel_last | REQ_LAST[i];
        sel_idx  = LW'(i);
      end
    end
  end

  // Next state, accept handshake and lock/timeout bookkeeping.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    abort_d = 1'b0;
    ready   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (UART_TXRDY && |REQ_VALID) begin
          ready   = pick;
          grant_d = pick;
          last_d  = sel_idx;
          data_d  = sel_data;
          lock_d  = !sel_last;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        scnt_d  = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (scnt_q == SET_END) begin
          scnt_d  = '0;
          state_d = ST_WAIT;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (UART_TXRDY) begin
          if (!lock_q) begin
            grant_d = '0;
            tcnt_d  = '0;
            state_d = ST_IDLE;
          end else if (|(REQ_VALID & grant_q)) begin
            ready   = grant_q;
            data_d  = sel_data;
            lock_d  = !sel_last;
            tcnt_d  = '0;
            state_d = ST_WRITE;
          end else if (LOCK_TIMEOUT != 0) begin
            if (tcnt_q == TO_END) begin
              abort_d = 1'b1;
              lock_d  = 1'b0;
              grant_d = '0;
              tcnt_d  = '0;
              state_d = ST_IDLE;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  // State register and registered UART/status outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      lock_q  <= 1'b0;
      grant_q <= '0;
      last_q  <= LAST_RST;
      data_q  <= '0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      abort_q <= 1'b0;
      csn_q   <= 1'b1;
      wen_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      abort_q <= abort_d;
      csn_q   <= (state_d != ST_WRITE);
      wen_q   <= (state_d != ST_WRITE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign REQ_READY  = RESET ? '0 : ready;
  assign UART_CSN   = csn_q;
  assign UART_WEN   = wen_q;
  assign UART_DATA  = data_q;
  assign GRANT      = grant_q;
  assign BUSY       = busy_q;
  assign LOCK_ABORT = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for
// uart_tx_arbiter (4 requesters, settle 2, timeout 8).
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int LT = 8;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [N-1:0]   REQ_VALID = '0;
  logic [N*8-1:0] REQ_DATA = '0;
  logic [N-1:0]   REQ_LAST = '0;
  logic [N-1:0]   REQ_READY;
  logic           UART_TXRDY = 1'b1;
  logic           UART_CSN, UART_WEN;
  logic [7:0]     UART_DATA;
  logic [N-1:0]   GRANT;
  logic           BUSY, LOCK_ABORT;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int dbl = 0;
  int wenmis = 0;
  logic prev_low = 1'b0;

  int         w_cyc[$];
  logic [7:0] w_dat[$];
  logic [N-1:0] w_gnt[$];

  int a, ab, r, c0, idx, viol;
  logic done0, found;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .SETTLE_CYCLES (S),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ_VALID  (REQ_VALID),
    .REQ_DATA   (REQ_DATA),
    .REQ_LAST   (REQ_LAST),
    .REQ_READY  (REQ_READY),
    .UART_TXRDY (UART_TXRDY),
    .UART_CSN   (UART_CSN),
    .UART_WEN   (UART_WEN),
    .UART_DATA  (UART_DATA),
    .GRANT      (GRANT),
    .BUSY       (BUSY),
    .LOCK_ABORT (LOCK_ABORT)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every write strobe seen on the UART pins.
  always @(negedge CLK) begin
    if (UART_WEN != UART_CSN) wenmis <= wenmis + 1;
    if (!UART_CSN) begin
      if (prev_low) dbl <= dbl + 1;
      w_cyc.push_back(cyc);
      w_dat.push_back(UART_DATA);
      w_gnt.push_back(GRANT);
    end
    prev_low <= !UART_CSN;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic sync();
    @(negedge CLK);
    #1;
  endtask

  task automatic clr();
    w_cyc.delete();
    w_dat.delete();
    w_gnt.delete();
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [7:0] d,
                         input logic l);
    REQ_VALID[i]     = v;
    REQ_DATA[8*i +: 8] = d;
    REQ_LAST[i]      = l;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    sync();
    sync();
    RESET = 1'b0;
    clr();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    sync();
    while (BUSY && k < 100) begin
      sync();
      k++;
    end
    chk(tag, BUSY, 0);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (w_cyc.size() < n && k < 300) begin
      sync();
      k++;
    end
    chk(tag, w_cyc.size() >= n, 1);
  endtask

  task automatic wait_ready(input int i, input string tag,
                            output int at);
    int k = 0;
    #1;
    while (!REQ_READY[i] && k < 50) begin
      sync();
      #1;
      k++;
    end
    at = cyc;
    chk(tag, REQ_READY[i], 1);
  endtask

  initial begin
    // reset values
    sync();
    sync();
    chk("rst_csn", UART_CSN, 1);
    chk("rst_wen", UART_WEN, 1);
    chk("rst_data", UART_DATA, 0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_grant", GRANT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_abort", LOCK_ABORT, 0);
    RESET = 1'b0;
    clr();

    // single byte after reset
    sync();
    set_req(0, 1'b1, 8'h55, 1'b1);
    #1;
    chk("t1_ready", REQ_READY, 4'b0001);
    c0 = cyc;
    sync();
    set_req(0, 1'b0, 8'h00, 1'b0);
    chk("t1_csn", UART_CSN, 0);
    chk("t1_wen", UART_WEN, 0);
    chk("t1_data", UART_DATA, 8'h55);
    chk("t1_grant", GRANT, 4'b0001);
    sync();
    chk("t1_csn_hi", UART_CSN, 1);
    wait_idle("t1_idle");
    chk("t1_grant0", GRANT, 0);
    chk("t1_nwr", w_cyc.size(), 1);
    if (w_cyc.size() > 0)
      chk("t1_wcyc", w_cyc[0], c0 + 1);

    // round-robin fairness
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 8'(8'h11 * (i + 1)), 1'b1);
    wait_writes(5, "t2_cnt");
    REQ_VALID = '0;
    wait_idle("t2_idle");
    for (int k = 0; k < 5; k++) begin
      if (k < w_cyc.size()) begin
        chk($sformatf("t2_gnt%0d", k), w_gnt[k],
            32'(1 << (k % 4)));
        chk($sformatf("t2_dat%0d", k), w_dat[k],
            32'(8'h11 * ((k % 4) + 1)));
        if (k > 0)
          chk($sformatf("t2_gap%0d", k),
              w_cyc[k] - w_cyc[k-1], S + 3);
      end
    end

    // packet lock: req2 sends 3 bytes, req0 waits
    clr();
    idx = 0;
    done0 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (idx == 3 && done0) break;
      sync();
      if (idx < 3)
        set_req(2, 1'b1, 8'(8'hB0 + idx), idx == 2);
      else
        set_req(2, 1'b0, 8'h00, 1'b0);
      set_req(0, !done0, 8'hA0, 1'b1);
      #1;
      if (REQ_READY[2]) idx++;
      if (REQ_READY[0]) done0 = 1'b1;
    end
    chk("t3_done", (idx == 3) && done0, 1);
    sync();
    REQ_VALID = '0;
    wait_idle("t3_idle");
    chk("t3_nwr", w_cyc.size(), 4);
    if (w_cyc.size() >= 4) begin
      chk("t3_d0", w_dat[0], 8'hB0);
      chk("t3_d1", w_dat[1], 8'hB1);
      chk("t3_d2", w_dat[2], 8'hB2);
      chk("t3_d3", w_dat[3], 8'hA0);
      chk("t3_g0", w_gnt[0], 4'b0100);
      chk("t3_g2", w_gnt[2], 4'b0100);
      chk("t3_g3", w_gnt[3], 4'b0001);
      chk("t3_gap1", w_cyc[1] - w_cyc[0], S + 2);
      chk("t3_gap2", w_cyc[2] - w_cyc[1], S + 2);
      chk("t3_gap3", w_cyc[3] - w_cyc[2], S + 3);
    end

    // TXRDY backpressure
    set_req(1, 1'b1, 8'hC1, 1'b1);
    wait_ready(1, "t4_rdy", a);
    sync();
    set_req(1, 1'b0, 8'h00, 1'b0);
    UART_TXRDY = 1'b0;
    set_req(3, 1'b1, 8'hD3, 1'b1);
    chk("t4_wdat", UART_DATA, 8'hC1);
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      sync();
      #1;
      if (REQ_READY != 0 || !UART_CSN) viol++;
    end
    chk("t4_hold", viol, 0);
    chk("t4_busy", BUSY, 1);
    chk("t4_gnt", GRANT, 4'b0010);
    sync();
    clr();
    UART_TXRDY = 1'b1;
    r = cyc;
    wait_writes(1, "t4_wr");
    if (w_cyc.size() > 0) begin
      chk("t4_lat", w_cyc[0] - r, 2);
      chk("t4_dat", w_dat[0], 8'hD3);
      chk("t4_g", w_gnt[0], 4'b1000);
    end
    set_req(3, 1'b0, 8'h00, 1'b0);
    wait_idle("t4_idle");

    // lock timeout
    set_req(0, 1'b1, 8'hE0, 1'b0);
    set_req(1, 1'b1, 8'hF1, 1'b1);
    wait_ready(0, "t5_rdy", a);
    chk("t5_rdy1", REQ_READY, 4'b0001);
    sync();
    set_req(0, 1'b0, 8'h00, 1'b0);
    clr();
    viol = 0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      sync();
      #1;
      if (LOCK_ABORT) begin
        found = 1'b1;
        break;
      end
      if (REQ_READY[1]) viol++;
    end
    ab = cyc;
    chk("t5_abort", found, 1);
    chk("t5_when", ab - a, S + 2 + LT);
    chk("t5_gnt0", GRANT, 0);
    chk("t5_nonown", viol, 0);
    sync();
    chk("t5_pulse", LOCK_ABORT, 0);
    wait_writes(1, "t5_wr");
    if (w_cyc.size() > 0) begin
      chk("t5_next", w_gnt[0], 4'b0010);
      chk("t5_dat", w_dat[0], 8'hF1);
      chk("t5_wcyc", w_cyc[0], ab + 1);
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    wait_idle("t5_idle");

    // reset mid-write
    set_req(2, 1'b1, 8'h77, 1'b1);
    for (int k = 0; k < 50; k++) begin
      sync();
      #1;
      if (!UART_CSN) break;
    end
    chk("t6_strobe", UART_CSN, 0);
    #1;
    RESET = 1'b1;
    set_req(0, 1'b1, 8'h10, 1'b1);
    #1;
    chk("t6_csn", UART_CSN, 1);
    chk("t6_wen", UART_WEN, 1);
    chk("t6_data", UART_DATA, 0);
    chk("t6_gnt", GRANT, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_ready", REQ_READY, 0);
    sync();
    chk("t6_csn2", UART_CSN, 1);
    chk("t6_ready2", REQ_READY, 0);
    RESET = 1'b0;
    clr();
    wait_writes(1, "t6_wr");
    if (w_cyc.size() > 0) begin
      chk("t6_first", w_gnt[0], 4'b0001);
      chk("t6_fdat", w_dat[0], 8'h10);
    end
    REQ_VALID = '0;
    wait_idle("t6_idle");

    chk("strobe_len", dbl, 0);
    chk("wen_eq_csn", wenmis, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the write side of one CoreUART instance between `NUM_REQ` independent byte sources in the fabric. It arbitrates round-robin, locks the grant for the duration of a multi-byte packet, and issues the single-cycle `CSN`/`WEN` write strobe. It then waits for `TXRDY` before offering the UART to anyone else. It sits between the fabric requesters and the CoreUART `CSN`/`WEN`/`DATA_IN`/`TXRDY` pins; the read side (`OEN`) is not touched.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `SETTLE_CYCLES`, default 2: cycles after a write strobe during which `TXRDY` is ignored, so a stale high is never sampled. Range 1..15.
- `LOCK_TIMEOUT`, default 1024: idle cycles a locked owner may stall before its lock is revoked. 0 means never revoke. Maximum 65535.
- `CLK` in 1: single clock, the same clock as CoreUART.
- `RESET` in 1: asynchronous, active-high reset.
- `REQ_VALID` in `NUM_REQ`: requester i has a byte.
- `REQ_DATA` in `NUM_REQ*8`: byte of requester i at `[8i+7:8i]`.
- `REQ_LAST` in `NUM_REQ`: byte is the last of its packet.
- `REQ_READY` out `NUM_REQ`: byte accepted this cycle (handshake = VALID & READY).
- `UART_TXRDY` in 1: CoreUART `TXRDY`.
- `UART_CSN` out 1: to CoreUART `CSN`, active low.
- `UART_WEN` out 1: to CoreUART `WEN`, active low.
- `UART_DATA` out 8: to CoreUART `DATA_IN`.
- `GRANT` out `NUM_REQ`: one-hot current owner, all zero when no owner.
- `BUSY` out 1: state is not IDLE.
- `LOCK_ABORT` out 1: one-cycle pulse when a lock is revoked by timeout.

## Operation
- States: IDLE, WRITE, SETTLE, WAIT.
- **IDLE**
  - Accept happens when `UART_TXRDY`=1 and any `REQ_VALID`=1.
  - Winner is the first valid requester searching upward from `(last+1) mod NUM_REQ`.
  - On accept: assert `REQ_READY[winner]`, latch `REQ_DATA` and `REQ_LAST`, set `GRANT`, update `last`, set lock = !`REQ_LAST`, go to WRITE.
  - If `TXRDY`=0, or no request is valid, nothing is accepted.
- **WRITE**
  - `UART_CSN`=0, `UART_WEN`=0, `UART_DATA`=latched byte, for exactly one cycle.
  - Go to SETTLE.
- **SETTLE**
  - Count `SETTLE_CYCLES` cycles, then go to WAIT.
- **WAIT**, when `UART_TXRDY`=1:
  - If unlocked: clear `GRANT`, go to IDLE. Arbitration happens in IDLE on the following cycle.
  - If locked and the owner's `REQ_VALID`=1: accept from the owner only, latch data and lock as in IDLE, go to WRITE.
  - If locked and the owner's `REQ_VALID`=0: increment the timeout counter.
    - When the counter reaches `LOCK_TIMEOUT`: pulse `LOCK_ABORT`, clear lock and `GRANT`, go to IDLE.
  - The counter clears on every accept and on every state exit.
- **WAIT**, when `UART_TXRDY`=0: hold. The timeout counter does not advance.
- `REQ_READY` is combinational from state, `TXRDY`, `REQ_VALID` and the grant logic. At most one bit is high, and only together with the matching `REQ_VALID`.
- A requester may drop `REQ_VALID` before being accepted; this has no side effect.
- Non-owners are never accepted while a lock is held.

## Timing
- **Reset values:**
  - `UART_CSN`=1, `UART_WEN`=1, `UART_DATA`=0.
  - `REQ_READY`=0, `GRANT`=0, `BUSY`=0, `LOCK_ABORT`=0.
  - State IDLE, lock clear, `last`=`NUM_REQ`-1, so requester 0 wins first.
- `UART_CSN`, `UART_WEN`, `UART_DATA`, `GRANT`, `BUSY` and `LOCK_ABORT` are registered. Reset forces the strobes high immediately, including in the middle of WRITE.
- The write strobe appears in the cycle after the accept cycle.
- Minimum byte period:
  - Locked stream: `SETTLE_CYCLES`+2 cycles (accept, WRITE, SETTLE..., WAIT/accept).
  - Unlocked: one extra IDLE cycle.
- Timeout: `LOCK_ABORT` is asserted `LOCK_TIMEOUT` cycles after the first WAIT cycle in which `TXRDY`=1 and the owner is stalled.
- Wrap-around: the search pointer wraps from `NUM_REQ`-1 to 0.
- Simultaneous requests are resolved purely by pointer order.

## Structure
- Shared package `uart_arb_pkg`:
  - State encoding constants.
  - Timeout counter width (16).
  - `SETTLE` counter width (4).
- One sub-module, `uart_rr_pick`: combinational round-robin one-hot picker with inputs `req`, `last` and output `pick`. It is reusable by a later RX-side distributor.

## Test plan
- **Single byte after reset.** `REQ_VALID`=0001, `DATA`=0x55, `LAST`=1, `TXRDY`=1.
  - `READY[0]` high in the accept cycle.
  - `CSN`/`WEN` low for exactly 1 cycle, one cycle later, with `UART_DATA`=0x55.
  - `GRANT` returns to 0.
- **Round-robin fairness.** All four requesters continuously valid with `LAST`=1.
  - Grants follow the order 0,1,2,3,0.
  - Each write is separated by ≥ `SETTLE_CYCLES`+3 cycles.
- **Packet lock.** Requester 2 sends 3 bytes (`LAST`=0,0,1) while requester 0 is valid throughout.
  - All three bytes from requester 2 are written back-to-back.
  - Requester 0 is granted next.
- **TXRDY backpressure.** Hold `TXRDY`=0 for 20 cycles after a write.
  - State stays in WAIT.
  - No `READY` and no strobe.
  - The next write occurs 2 cycles after `TXRDY` rises.
- **Lock timeout.** `LOCK_TIMEOUT`=8; owner sends `LAST`=0 and then drops `VALID` while `TXRDY`=1.
  - `LOCK_ABORT` pulses after exactly 8 cycles.
  - Requester 1 is granted next.
- **Reset mid-write.** Assert `RESET` during WRITE.
  - `CSN`/`WEN` go to 1 the same cycle.
  - All outputs hold their reset values.
  - After release, requester 0 wins first.
